// File: rtl/register_array_kv_pq_if.sv
// Request/response bundle for the sorted key/value priority queue.
// The queue sits on the slave side; whoever issues push/pop/replace is the master.
interface register_array_kv_pq_if #(
  parameter int KEY_WIDTH  = 16,
  parameter int VAL_WIDTH  = 8,
  parameter int SIZE_WIDTH = 4
);
  logic                  i_wrt;
  logic                  i_read;
  logic                  i_clear;
  logic [KEY_WIDTH-1:0]  i_key;
  logic [VAL_WIDTH-1:0]  i_val;
  logic                  o_full;
  logic                  o_empty;
  logic                  o_valid;
  logic [KEY_WIDTH-1:0]  o_key;
  logic [VAL_WIDTH-1:0]  o_val;
  logic [SIZE_WIDTH-1:0] o_size;
  logic                  o_drop;
  logic [KEY_WIDTH-1:0]  o_drop_key;
  logic [VAL_WIDTH-1:0]  o_drop_val;
  logic                  o_err;

  modport master (
    output i_wrt, i_read, i_clear, i_key, i_val,
    input  o_full, o_empty, o_valid, o_key, o_val, o_size,
           o_drop, o_drop_key, o_drop_val, o_err
  );

  modport slave (
    input  i_wrt, i_read, i_clear, i_key, i_val,
    output o_full, o_empty, o_valid, o_key, o_val, o_size,
           o_drop, o_drop_key, o_drop_val, o_err
  );
endinterface

// File: rtl/register_array_kv_pq.sv
// Shift-register priority queue of {valid, key, value} cells kept sorted best-first.
// Enqueue, dequeue and replace all finish in one cycle via per-cell compare/select.
module register_array_kv_pq #(
  parameter int QUEUE_SIZE = 8,
  parameter int KEY_WIDTH  = 16,
  parameter int VAL_WIDTH  = 8,
  parameter int MAX_FIRST  = 1,
  parameter int ENQ_ENA    = 1
) (
  input logic                  i_CLK,
  input logic                  i_RSTn,
  register_array_kv_pq_if.slave bus
);
  localparam int SW = $clog2(QUEUE_SIZE + 1);
  localparam logic [SW-1:0] FULL_CNT = SW'(QUEUE_SIZE);
  localparam logic [SW-1:0] ONE      = SW'(1);

  logic                 vld_q [QUEUE_SIZE];
  logic                 vld_d [QUEUE_SIZE];
  logic [KEY_WIDTH-1:0] key_q [QUEUE_SIZE];
  logic [KEY_WIDTH-1:0] key_d [QUEUE_SIZE];
  logic [VAL_WIDTH-1:0] val_q [QUEUE_SIZE];
  logic [VAL_WIDTH-1:0] val_d [QUEUE_SIZE];
  logic [SW-1:0]        size_q, size_d;
  logic                 drop_q, drop_d;
  logic [KEY_WIDTH-1:0] drop_key_q, drop_key_d;
  logic [VAL_WIDTH-1:0] drop_val_q, drop_val_d;
  logic                 err_q, err_d;

  logic                 full, empty, rep_ne;
  logic                 base_vld [QUEUE_SIZE];
  logic [KEY_WIDTH-1:0] base_key [QUEUE_SIZE];
  logic [VAL_WIDTH-1:0] base_val [QUEUE_SIZE];
  logic [SW-1:0]        base_size;
  logic [QUEUE_SIZE-1:0] ge;

  function automatic logic better(input logic [KEY_WIDTH-1:0] a, input logic [KEY_WIDTH-1:0] b);
    if (MAX_FIRST != 0) return a > b;
    else                return a < b;
  endfunction

  // Replace is modelled as "pop head, then insert": base is the array the insert sees.
  always_comb begin
    full   = (size_q == FULL_CNT);
    empty  = (size_q == '0);
    rep_ne = bus.i_wrt && bus.i_read && !empty;
    for (int i = 0; i < QUEUE_SIZE - 1; i++) begin
      base_vld[i] = rep_ne ? vld_q[i+1] : vld_q[i];
      base_key[i] = rep_ne ? key_q[i+1] : key_q[i];
      base_val[i] = rep_ne ? val_q[i+1] : val_q[i];
    end
    base_vld[QUEUE_SIZE-1] = rep_ne ? 1'b0 : vld_q[QUEUE_SIZE-1];
    base_key[QUEUE_SIZE-1] = rep_ne ? '0   : key_q[QUEUE_SIZE-1];
    base_val[QUEUE_SIZE-1] = rep_ne ? '0   : val_q[QUEUE_SIZE-1];
    base_size = rep_ne ? size_q - ONE : size_q;
    // Strict compare keeps ties FIFO; ge is monotonic because the array is sorted.
    for (int i = 0; i < QUEUE_SIZE; i++) begin
      ge[i] = !base_vld[i] || better(bus.i_key, base_key[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < QUEUE_SIZE; i++) begin
      vld_d[i] = vld_q[i];
      key_d[i] = key_q[i];
      val_d[i] = val_q[i];
    end
    size_d     = size_q;
    drop_d     = 1'b0;
    drop_key_d = drop_key_q;
    drop_val_d = drop_val_q;
    err_d      = 1'b0;

    if (bus.i_clear) begin
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        vld_d[i] = 1'b0;
        key_d[i] = '0;
        val_d[i] = '0;
      end
      size_d = '0;
    end else if (bus.i_wrt && (bus.i_read || ENQ_ENA != 0)) begin
      if (full && !rep_ne && !ge[QUEUE_SIZE-1]) begin
        drop_d     = 1'b1;
        drop_key_d = bus.i_key;
        drop_val_d = bus.i_val;
      end else begin
        vld_d[0] = ge[0] ? 1'b1        : base_vld[0];
        key_d[0] = ge[0] ? bus.i_key   : base_key[0];
        val_d[0] = ge[0] ? bus.i_val   : base_val[0];
        for (int i = 1; i < QUEUE_SIZE; i++) begin
          if (ge[i] && !ge[i-1]) begin
            vld_d[i] = 1'b1;
            key_d[i] = bus.i_key;
            val_d[i] = bus.i_val;
          end else if (ge[i]) begin
            vld_d[i] = base_vld[i-1];
            key_d[i] = base_key[i-1];
            val_d[i] = base_val[i-1];
          end else begin
            vld_d[i] = base_vld[i];
            key_d[i] = base_key[i];
            val_d[i] = base_val[i];
          end
        end
        if (full && !rep_ne) begin
          drop_d     = 1'b1;
          drop_key_d = base_key[QUEUE_SIZE-1];
          drop_val_d = base_val[QUEUE_SIZE-1];
        end else begin
          size_d = base_size + ONE;
        end
      end
    end else if (bus.i_read) begin
      if (empty) begin
        err_d = 1'b1;
      end else begin
        for (int i = 0; i < QUEUE_SIZE - 1; i++) begin
          vld_d[i] = vld_q[i+1];
          key_d[i] = key_q[i+1];
          val_d[i] = val_q[i+1];
        end
        vld_d[QUEUE_SIZE-1] = 1'b0;
        key_d[QUEUE_SIZE-1] = '0;
        val_d[QUEUE_SIZE-1] = '0;
        size_d = size_q - ONE;
      end
    end else if (bus.i_wrt) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        vld_q[i] <= 1'b0;
        key_q[i] <= '0;
        val_q[i] <= '0;
      end
      size_q     <= '0;
      drop_q     <= 1'b0;
      drop_key_q <= '0;
      drop_val_q <= '0;
      err_q      <= 1'b0;
    end else begin
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        vld_q[i] <= vld_d[i];
        key_q[i] <= key_d[i];
        val_q[i] <= val_d[i];
      end
      size_q     <= size_d;
      drop_q     <= drop_d;
      drop_key_q <= drop_key_d;
      drop_val_q <= drop_val_d;
      err_q      <= err_d;
    end
  end

  assign bus.o_full     = (size_q == FULL_CNT);
  assign bus.o_empty    = (size_q == '0);
  assign bus.o_valid    = vld_q[0];
  assign bus.o_key      = key_q[0];
  assign bus.o_val      = val_q[0];
  assign bus.o_size     = size_q;
  assign bus.o_drop     = drop_q;
  assign bus.o_drop_key = drop_key_q;
  assign bus.o_drop_val = drop_val_q;
  assign bus.o_err      = err_q;
endmodule

// File: tb/tb_register_array_kv_pq.sv
// Directed bench: three queue configurations driven from one vector table,
// plus hand sequences for reset state and asynchronous reset mid-op.
module tb_register_array_kv_pq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  register_array_kv_pq_if #(.KEY_WIDTH(16), .VAL_WIDTH(8), .SIZE_WIDTH(3)) ifa ();
  register_array_kv_pq_if #(.KEY_WIDTH(16), .VAL_WIDTH(8), .SIZE_WIDTH(3)) ifb ();
  register_array_kv_pq_if #(.KEY_WIDTH(16), .VAL_WIDTH(8), .SIZE_WIDTH(4)) ifc ();

  register_array_kv_pq #(.QUEUE_SIZE(4), .KEY_WIDTH(16), .VAL_WIDTH(8), .MAX_FIRST(1), .ENQ_ENA(1))
    dut_a (.i_CLK(clk), .i_RSTn(rst_n), .bus(ifa));
  register_array_kv_pq #(.QUEUE_SIZE(4), .KEY_WIDTH(16), .VAL_WIDTH(8), .MAX_FIRST(0), .ENQ_ENA(1))
    dut_b (.i_CLK(clk), .i_RSTn(rst_n), .bus(ifb));
  register_array_kv_pq #(.QUEUE_SIZE(8), .KEY_WIDTH(16), .VAL_WIDTH(8), .MAX_FIRST(1), .ENQ_ENA(0))
    dut_c (.i_CLK(clk), .i_RSTn(rst_n), .bus(ifc));

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    int          u;
    bit          clr, wrt, rd;
    logic [15:0] key;
    logic [7:0]  val;
    int          size;
    logic [15:0] ekey;
    logic [7:0]  evl;
    bit          drop;
    logic [15:0] dkey;
    logic [7:0]  dval;
    bit          err;
  } vec_t;

  typedef struct {
    int          size;
    logic [15:0] key;
    logic [7:0]  val;
    logic        valid, empty, full, drop, err;
    logic [15:0] dkey;
    logic [7:0]  dval;
  } obs_t;

  vec_t vt[$];

  function automatic void add(int u, bit c, bit w, bit r, logic [15:0] k, logic [7:0] v,
                              int s, logic [15:0] ek, logic [7:0] ev,
                              bit d, logic [15:0] dk, logic [7:0] dv, bit e);
    vec_t x;
    x.u = u; x.clr = c; x.wrt = w; x.rd = r; x.key = k; x.val = v;
    x.size = s; x.ekey = ek; x.evl = ev; x.drop = d; x.dkey = dk; x.dval = dv; x.err = e;
    vt.push_back(x);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got %0h expected %0h", nm, idx, act, exp);
  endtask

  task automatic idle_all();
    ifa.i_clear = 0; ifa.i_wrt = 0; ifa.i_read = 0; ifa.i_key = '0; ifa.i_val = '0;
    ifb.i_clear = 0; ifb.i_wrt = 0; ifb.i_read = 0; ifb.i_key = '0; ifb.i_val = '0;
    ifc.i_clear = 0; ifc.i_wrt = 0; ifc.i_read = 0; ifc.i_key = '0; ifc.i_val = '0;
  endtask

  task automatic drive(input vec_t x);
    idle_all();
    case (x.u)
      0: begin ifa.i_clear = x.clr; ifa.i_wrt = x.wrt; ifa.i_read = x.rd; ifa.i_key = x.key; ifa.i_val = x.val; end
      1: begin ifb.i_clear = x.clr; ifb.i_wrt = x.wrt; ifb.i_read = x.rd; ifb.i_key = x.key; ifb.i_val = x.val; end
      default: begin ifc.i_clear = x.clr; ifc.i_wrt = x.wrt; ifc.i_read = x.rd; ifc.i_key = x.key; ifc.i_val = x.val; end
    endcase
  endtask

  function automatic obs_t get(int u);
    obs_t o;
    case (u)
      0: begin
        o.size = int'(ifa.o_size); o.key = ifa.o_key; o.val = ifa.o_val; o.valid = ifa.o_valid;
        o.empty = ifa.o_empty; o.full = ifa.o_full; o.drop = ifa.o_drop; o.err = ifa.o_err;
        o.dkey = ifa.o_drop_key; o.dval = ifa.o_drop_val;
      end
      1: begin
        o.size = int'(ifb.o_size); o.key = ifb.o_key; o.val = ifb.o_val; o.valid = ifb.o_valid;
        o.empty = ifb.o_empty; o.full = ifb.o_full; o.drop = ifb.o_drop; o.err = ifb.o_err;
        o.dkey = ifb.o_drop_key; o.dval = ifb.o_drop_val;
      end
      default: begin
        o.size = int'(ifc.o_size); o.key = ifc.o_key; o.val = ifc.o_val; o.valid = ifc.o_valid;
        o.empty = ifc.o_empty; o.full = ifc.o_full; o.drop = ifc.o_drop; o.err = ifc.o_err;
        o.dkey = ifc.o_drop_key; o.dval = ifc.o_drop_val;
      end
    endcase
    return o;
  endfunction

  initial begin
    obs_t o;
    int   qs;

    rst_n = 1'b0;
    idle_all();
    repeat (3) @(posedge clk);
    #1;
    o = get(0);
    chk("rst_size",  -1, o.size, 0);
    chk("rst_empty", -1, o.empty, 1);
    chk("rst_full",  -1, o.full, 0);
    chk("rst_key",   -1, o.key, 0);
    chk("rst_val",   -1, o.val, 0);
    chk("rst_drop",  -1, o.drop, 0);
    chk("rst_dkey",  -1, o.dkey, 0);
    chk("rst_err",   -1, o.err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    //  u  clr wrt rd key    val     size ekey   eval   drp dkey   dval   err
    add(0, 0, 0, 0, 16'd0, 8'h00,  0, 16'd0, 8'h00, 0, 16'd0, 8'h00, 0);
    add(0, 0, 1, 0, 16'd5, 8'hA0,  1, 16'd5, 8'hA0, 0, 16'd0, 8'h00, 0);
    add(0, 0, 1, 0, 16'd9, 8'hB0,  2, 16'd9, 8'hB0, 0, 16'd0, 8'h00, 0);
    add(0, 0, 1, 0, 16'd3, 8'hC0,  3, 16'd9, 8'hB0, 0, 16'd0, 8'h00, 0);
    add(0, 0, 1, 0, 16'd9, 8'hD0,  4, 16'd9, 8'hB0, 0, 16'd0, 8'h00, 0);
    add(0, 0, 0, 1, 16'd0, 8'h00,  3, 16'd9, 8'hD0, 0, 16'd0, 8'h00, 0);
    add(0, 0, 0, 1, 16'd0, 8'h00,  2, 16'd5, 8'hA0, 0, 16'd0, 8'h00, 0);
    add(0, 0, 0, 1, 16'd0, 8'h00,  1, 16'd3, 8'hC0, 0, 16'd0, 8'h00, 0);
    add(0, 0, 0, 1, 16'd0, 8'h00,  0, 16'd0, 8'h00, 0, 16'd0, 8'h00, 0);
    add(0, 0, 0, 1, 16'd0, 8'h00,  0, 16'd0, 8'h00, 0, 16'd0, 8'h00, 1);
    add(0, 0, 0, 0, 16'd0, 8'h00,  0, 16'd0, 8'h00, 0, 16'd0, 8'h00, 0);
    // fill {9,7,5,3}, then evict tail, then reject a worse key
    add(0, 0, 1, 0, 16'd7, 8'h71,  1, 16'd7, 8'h71, 0, 16'd0, 8'h00, 0);
    add(0, 0, 1, 0, 16'd3, 8'h31,  2, 16'd7, 8'h71, 0, 16'd0, 8'h00, 0);
    add(0, 0, 1, 0, 16'd9, 8'h91,  3, 16'd9, 8'h91, 0, 16'd0, 8'h00, 0);
    add(0, 0, 1, 0, 16'd5, 8'h51,  4, 16'd9, 8'h91, 0, 16'd0, 8'h00, 0);
    add(0, 0, 1, 0, 16'd4, 8'h41,  4, 16'd9, 8'h91, 1, 16'd3, 8'h31, 0);
    add(0, 0, 1, 0, 16'd2, 8'h21,  4, 16'd9, 8'h91, 1, 16'd2, 8'h21, 0);
    add(0, 0, 0, 1, 16'd0, 8'h00,  3, 16'd7, 8'h71, 0, 16'd0, 8'h00, 0);
    add(0, 0, 0, 1, 16'd0, 8'h00,  2, 16'd5, 8'h51, 0, 16'd0, 8'h00, 0);
    add(0, 0, 0, 1, 16'd0, 8'h00,  1, 16'd4, 8'h41, 0, 16'd0, 8'h00, 0);
    add(0, 0, 0, 1, 16'd0, 8'h00,  0, 16'd0, 8'h00, 0, 16'd0, 8'h00, 0);
    // replace on {9,5,3}, then replace on empty
    add(0, 0, 1, 0, 16'd9, 8'h92,  1, 16'd9, 8'h92, 0, 16'd0, 8'h00, 0);
    add(0, 0, 1, 0, 16'd5, 8'h52,  2, 16'd9, 8'h92, 0, 16'd0, 8'h00, 0);
    add(0, 0, 1, 0, 16'd3, 8'h32,  3, 16'd9, 8'h92, 0, 16'd0, 8'h00, 0);
    add(0, 0, 1, 1, 16'd6, 8'h62,  3, 16'd6, 8'h62, 0, 16'd0, 8'h00, 0);
    add(0, 0, 0, 1, 16'd0, 8'h00,  2, 16'd5, 8'h52, 0, 16'd0, 8'h00, 0);
    add(0, 0, 0, 1, 16'd0, 8'h00,  1, 16'd3, 8'h32, 0, 16'd0, 8'h00, 0);
    add(0, 0, 0, 1, 16'd0, 8'h00,  0, 16'd0, 8'h00, 0, 16'd0, 8'h00, 0);
    add(0, 0, 1, 1, 16'd7, 8'h72,  1, 16'd7, 8'h72, 0, 16'd0, 8'h00, 0);
    add(0, 0, 0, 1, 16'd0, 8'h00,  0, 16'd0, 8'h00, 0, 16'd0, 8'h00, 0);
    // clear wins over a simultaneous push
    add(0, 0, 1, 0, 16'd4, 8'h43,  1, 16'd4, 8'h43, 0, 16'd0, 8'h00, 0);
    add(0, 0, 1, 0, 16'd2, 8'h23,  2, 16'd4, 8'h43, 0, 16'd0, 8'h00, 0);
    add(0, 1, 1, 0, 16'd8, 8'h83,  0, 16'd0, 8'h00, 0, 16'd0, 8'h00, 0);
    // min-first queue: key 0 is a real entry
    add(1, 0, 1, 0, 16'd5, 8'h05,  1, 16'd5, 8'h05, 0, 16'd0, 8'h00, 0);
    add(1, 0, 1, 0, 16'd0, 8'h00,  2, 16'd0, 8'h00, 0, 16'd0, 8'h00, 0);
    add(1, 0, 1, 0, 16'd8, 8'h08,  3, 16'd0, 8'h00, 0, 16'd0, 8'h00, 0);
    add(1, 0, 0, 1, 16'd0, 8'h00,  2, 16'd5, 8'h05, 0, 16'd0, 8'h00, 0);
    add(1, 0, 0, 1, 16'd0, 8'h00,  1, 16'd8, 8'h08, 0, 16'd0, 8'h00, 0);
    add(1, 0, 0, 1, 16'd0, 8'h00,  0, 16'd0, 8'h00, 0, 16'd0, 8'h00, 0);
    // standalone enqueue disabled; replace still allowed
    add(2, 0, 1, 0, 16'd4, 8'h44,  0, 16'd0, 8'h00, 0, 16'd0, 8'h00, 1);
    add(2, 0, 0, 0, 16'd0, 8'h00,  0, 16'd0, 8'h00, 0, 16'd0, 8'h00, 0);
    add(2, 0, 1, 1, 16'd6, 8'h66,  1, 16'd6, 8'h66, 0, 16'd0, 8'h00, 0);
    add(2, 0, 1, 0, 16'd9, 8'h99,  1, 16'd6, 8'h66, 0, 16'd0, 8'h00, 1);
    add(2, 0, 0, 1, 16'd0, 8'h00,  0, 16'd0, 8'h00, 0, 16'd0, 8'h00, 0);

    #1;
    foreach (vt[i]) begin
      drive(vt[i]);
      @(posedge clk);
      #1;
      o  = get(vt[i].u);
      qs = (vt[i].u == 2) ? 8 : 4;
      chk("size",  i, o.size,  vt[i].size);
      chk("key",   i, o.key,   vt[i].ekey);
      chk("val",   i, o.val,   vt[i].evl);
      chk("valid", i, o.valid, (vt[i].size != 0));
      chk("empty", i, o.empty, (vt[i].size == 0));
      chk("full",  i, o.full,  (vt[i].size == qs));
      chk("drop",  i, o.drop,  vt[i].drop);
      chk("err",   i, o.err,   vt[i].err);
      if (vt[i].drop) begin
        chk("drop_key", i, o.dkey, vt[i].dkey);
        chk("drop_val", i, o.dval, vt[i].dval);
      end
    end
    idle_all();

    // async reset between edges during an enqueue into {7,1}
    ifa.i_wrt = 1; ifa.i_key = 16'd7; ifa.i_val = 8'h17;
    @(posedge clk); #1;
    ifa.i_key = 16'd1; ifa.i_val = 8'h11;
    @(posedge clk); #1;
    o = get(0);
    chk("pre_rst_size", -2, o.size, 2);
    chk("pre_rst_key",  -2, o.key, 7);
    ifa.i_key = 16'd5; ifa.i_val = 8'h15;
    #3;
    rst_n = 1'b0;
    #1;
    o = get(0);
    chk("arst_size",  -3, o.size, 0);
    chk("arst_empty", -3, o.empty, 1);
    chk("arst_valid", -3, o.valid, 0);
    chk("arst_key",   -3, o.key, 0);
    chk("arst_val",   -3, o.val, 0);
    chk("arst_dkey",  -3, o.dkey, 0);
    chk("arst_dval",  -3, o.dval, 0);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    o = get(0);
    chk("post_rst_size", -4, o.size, 1);
    chk("post_rst_key",  -4, o.key, 5);
    chk("post_rst_val",  -4, o.val, 8'h15);
    chk("post_rst_err",  -4, o.err, 0);
    idle_all();
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
